// File: rtl/rfid_spi_master.sv
// Mode-0 SPI master for the RFID/crypto peripheral: sends a {plaintext, key} frame, waits for done, reads back the cyphertext.
// Optional WAIT_DONE watchdog is compiled in when RFID_SPI_MASTER_TIMEOUT_EN is defined.
module rfid_spi_master #(
  parameter int CLK_DIV        = 4,
  parameter int TX_BITS        = 256,
  parameter int RX_BITS        = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TX_BITS-1:0] tx_data,
  output logic               busy,
  output logic               sck,
  output logic               mosi,
  input  logic               miso,
  output logic               load,
  input  logic               done_in,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               timeout
);

  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAXB = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
  localparam int CW   = $clog2(MAXB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX   = 3'd1,
    S_WAIT = 3'd2,
    S_RX   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [CW-1:0]      bit_q, bit_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               rx_valid_q, rx_valid_d;
  logic [TX_BITS-2:0] tx_sh_q, tx_sh_d;
  logic [RX_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [RX_BITS-1:0] rx_data_q, rx_data_d;
  logic               done_s1_q, done_s1_d;
  logic               done_s2_q, done_s2_d;
  logic               half_done;

`ifdef RFID_SPI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Handshake: start is a one-cycle request sampled only in IDLE (busy=0); it is
  // never queued, and busy stays high from the next cycle until IDLE is re-entered.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    load_d     = load_q;
    busy_d     = busy_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    half_done  = (div_q == DW'(CLK_DIV - 1));
`ifdef RFID_SPI_MASTER_TIMEOUT_EN
    timeout_d  = 1'b0;
    to_cnt_d   = (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TX;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          mosi_d  = tx_data[TX_BITS-1];
          tx_sh_d = tx_data[TX_BITS-2:0];
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_TX: begin
        if (!half_done) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == CW'(TX_BITS - 1)) begin
              state_d = S_WAIT;
              load_d  = 1'b0;
              mosi_d  = 1'b0;
              bit_d   = '0;
            end else begin
              // Falling edge: present the next bit while sck is low.
              bit_d   = bit_q + 1'b1;
              mosi_d  = tx_sh_q[TX_BITS-2];
              tx_sh_d = {tx_sh_q[TX_BITS-3:0], 1'b0};
            end
          end
        end
      end
      S_WAIT: begin
        if (done_s2_q) begin
          state_d = S_RX;
          div_d   = '0;
          bit_d   = '0;
        end
`ifdef RFID_SPI_MASTER_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
`endif
      end
      S_RX: begin
        if (!half_done) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[RX_BITS-2:0], miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == CW'(RX_BITS - 1)) begin
              state_d    = S_DONE;
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              bit_d      = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        load_d  = 1'b0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // Synchroniser only runs while waiting, so a done left high from earlier still
  // pays the full two-flop latency after TX ends.
  always_comb begin
    done_s1_d = 1'b0;
    done_s2_d = 1'b0;
    if (state_d == S_WAIT) begin
      done_s1_d = done_in;
      done_s2_d = done_s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      done_s1_q  <= 1'b0;
      done_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      done_s1_q  <= done_s1_d;
      done_s2_q  <= done_s2_d;
    end
  end

`ifdef RFID_SPI_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy     = busy_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign load     = load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_rfid_spi_master.sv
// Directed bench for rfid_spi_master: table of transactions against a peripheral model plus reset and timeout sequences.
module tb_rfid_spi_master;
  localparam int CLK_DIV        = 2;
  localparam int TX_BITS        = 256;
  localparam int RX_BITS        = 128;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NV             = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [TX_BITS-1:0] tx_data;
  logic               busy, sck, mosi, load, rx_valid, timeout;
  logic               miso, done_in;
  logic [RX_BITS-1:0] rx_data;

  rfid_spi_master #(
    .CLK_DIV(CLK_DIV), .TX_BITS(TX_BITS), .RX_BITS(RX_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy), .sck(sck),
    .mosi(mosi), .miso(miso), .load(load), .done_in(done_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .timeout(timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [TX_BITS-1:0] tx;
    logic [RX_BITS-1:0] ct;
    int                 d;      // cycles after load falls before done_in rises (-1: never)
    bit                 early;  // done_in already high before the transaction
    bit                 drop;   // drop done_in after the first RX edge
    bit                 poke;   // extra start pulses while busy and in the DONE cycle
    int                 exp_busy;
    int                 exp_gap;
  } vec_t;

  vec_t vecs[NV];

  int n_tests;
  int n_fail;
  logic [RX_BITS-1:0] exp_q[$];
  logic [RX_BITS-1:0] ct_cur;

  int r_busy, r_load, r_txr, r_rxr, r_badper, r_badhi, r_viol, r_rv, r_to, r_gap, r_togap;
  logic [TX_BITS-1:0] r_cap;
  logic r_mosi_wait;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every rx_valid must match the oldest expected cyphertext
  task automatic sb_check();
    logic [RX_BITS-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected_valid: got rx_data %0h with no transaction pending", rx_data);
    end else begin
      e = exp_q.pop_front();
      chk("sb_rx_data", rx_data, e);
    end
  endtask

  // driver + peripheral model, sampled on the falling clk edge
  task automatic run_txn(input logic [TX_BITS-1:0] tx, input logic [RX_BITS-1:0] ct, input int d,
                         input bit early, input bit drop, input bit poke, input bit expect_rx);
    int cyc, last_rise, fall_cyc, hi_run;
    bit sck_p, mosi_p, load_p, rx_phase, fin;
    ct_cur = ct; tx_data = tx;
    r_busy = 0; r_load = 0; r_txr = 0; r_rxr = 0; r_badper = 0; r_badhi = 0;
    r_viol = 0; r_rv = 0; r_to = 0; r_gap = -1; r_togap = -1; r_cap = '0; r_mosi_wait = 1'b1;
    if (expect_rx) exp_q.push_back(ct);
    done_in = early;
    miso = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_load", load, 1);
    chk("accept_mosi", mosi, tx[TX_BITS-1]);
    chk("accept_sck", sck, 0);
    sck_p = 1'b0; mosi_p = mosi; load_p = 1'b1; rx_phase = 1'b0; fin = 1'b0;
    last_rise = -1; fall_cyc = 0; hi_run = 0; cyc = 0;
    while (!fin && cyc < 3000) begin
      if (busy) r_busy++;
      if (load) r_load++;
      if (sck && (mosi !== mosi_p)) r_viol++;
      if (sck) hi_run++;
      else if (sck_p) begin
        if (hi_run != CLK_DIV) r_badhi++;
        hi_run = 0;
      end
      if (sck && !sck_p) begin
        if (last_rise >= 0 && (cyc - last_rise) != 2 * CLK_DIV) r_badper++;
        last_rise = cyc;
        if (load) begin
          r_txr++;
          r_cap = {r_cap[TX_BITS-2:0], mosi};
        end else begin
          r_rxr++;
          if (r_rxr == 1) r_gap = cyc - fall_cyc;
        end
      end
      if (!load && load_p) begin
        rx_phase = 1'b1; fall_cyc = cyc; last_rise = -1; r_mosi_wait = mosi;
      end
      if (rx_phase && d >= 0 && !early && (cyc - fall_cyc) == d) done_in = 1'b1;
      if (drop && r_rxr >= 1) done_in = 1'b0;
      if (rx_valid) begin
        r_rv++;
        sb_check();
      end
      if (timeout) begin
        r_to++;
        r_togap = cyc - fall_cyc;
      end
      if (poke && (cyc == 50 || rx_valid)) start = 1'b1;
      else start = 1'b0;
      miso = (rx_phase && r_rxr < RX_BITS) ? ct_cur[RX_BITS-1-r_rxr] : 1'b0;
      if (!busy) fin = 1'b1;
      sck_p = sck; mosi_p = mosi; load_p = load;
      cyc++;
      @(negedge clk);
    end
    chk("txn_within_budget", fin, 1);
    start = 1'b0; done_in = 1'b0; miso = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_load", load, 0);
    chk("idle_sck", sck, 0);
  endtask

  task automatic check_vec(input vec_t v);
    chk("tx_rises", r_txr, TX_BITS);
    chk("tx_frame", r_cap, v.tx);
    chk("load_cycles", r_load, TX_BITS * 2 * CLK_DIV);
    chk("sck_period", r_badper, 0);
    chk("sck_high_len", r_badhi, 0);
    chk("mosi_stable", r_viol, 0);
    chk("mosi_wait", r_mosi_wait, 0);
    chk("rx_rises", r_rxr, RX_BITS);
    chk("rx_valid_pulses", r_rv, 1);
    chk("rx_first_gap", r_gap, v.exp_gap);
    chk("busy_cycles", r_busy, v.exp_busy);
    chk("rx_data_final", rx_data, v.ct);
    chk("rx_first_bit", rx_data[RX_BITS-1], v.ct[RX_BITS-1]);
    chk("timeout_pulses", r_to, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; miso = 1'b0; done_in = 1'b0; tx_data = '0;
    vecs[0] = '{{128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F},
                128'h69C4E0D86A7B0430D8CDB78070B4C55A, 0, 1'b0, 1'b0, 1'b0, 1540, 5};
    vecs[1] = '{{8{32'hA5A5_5A5A}}, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, -1, 1'b1, 1'b0, 1'b1, 1539, 4};
    vecs[2] = '{{128'hFFFF0000FFFF0000123456789ABCDEF0, 128'h0F0F0F0F00000001800000007E7E7E7E},
                128'h0123456789ABCDEFFEDCBA9876543210, 5, 1'b0, 1'b1, 1'b0, 1545, 10};

    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset around cycle 100 of a transaction with an all-ones frame
    tx_data = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (98) @(negedge clk);
    chk("midtx_load_before", load, 1);
    chk("midtx_mosi_before", mosi, 1);
    #2 reset = 1'b1;
    #1;
    chk("midtx_sck", sck, 0);
    chk("midtx_load", load, 0);
    chk("midtx_busy", busy, 0);
    chk("midtx_mosi", mosi, 0);
    chk("midtx_rx_valid", rx_valid, 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_load", load, 0);

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].tx, vecs[i].ct, vecs[i].d, vecs[i].early, vecs[i].drop, vecs[i].poke, 1'b1);
      check_vec(vecs[i]);
    end

`ifdef RFID_SPI_MASTER_TIMEOUT_EN
    run_txn(vecs[0].tx, vecs[0].ct, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_pulses", r_to, 1);
    chk("to_gap", r_togap, TIMEOUT_CYCLES);
    chk("to_busy_cycles", r_busy, TX_BITS * 2 * CLK_DIV + TIMEOUT_CYCLES);
    chk("to_rx_valid", r_rv, 0);
    chk("to_rx_rises", r_rxr, 0);
    chk("to_rx_data_kept", rx_data, vecs[NV-1].ct);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
